// File: rtl/cpu_pkg.sv
// Shared CPU datapath package.
// Holds the multiplier width, the multiplier FSM state type, and the
// Booth recoding constants used by the multiplier step logic.
package cpu_pkg;

  localparam int MULT_WIDTH = 32;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } mult_state_t;

  // {Q[0], q_1} codes that trigger an add or a subtract of M
  localparam logic [1:0] BOOTH_ADD = 2'b01;
  localparam logic [1:0] BOOTH_SUB = 2'b10;

endpackage

// File: rtl/mult_booth_step.sv
// One radix-2 Booth step: conditional add/sub of M into A, then an
// arithmetic shift right of {A, Q, q_1} by one bit. Purely combinational.
// Ports:
//   i_a  [WIDTH:0]   accumulator in
//   i_m  [WIDTH:0]   sign-extended multiplicand
//   i_q  [WIDTH-1:0] multiplier / low product bits in
//   i_q1             previous Q[0]
//   o_a, o_q, o_q1   register values after the step
module mult_booth_step
  import cpu_pkg::*;
#(
  parameter int WIDTH = MULT_WIDTH
) (
  input  logic [WIDTH:0]   i_a,
  input  logic [WIDTH:0]   i_m,
  input  logic [WIDTH-1:0] i_q,
  input  logic             i_q1,
  output logic [WIDTH:0]   o_a,
  output logic [WIDTH-1:0] o_q,
  output logic             o_q1
);

  logic [WIDTH:0] w_sum;

  always_comb begin
    w_sum = i_a;
    case ({i_q[0], i_q1})
      BOOTH_ADD: w_sum = i_a + i_m;
      BOOTH_SUB: w_sum = i_a - i_m;
      default:   w_sum = i_a;
    endcase
  end

  // Arithmetic shift: A's MSB is replicated, A's LSB moves into Q's MSB.
  assign o_a  = {w_sum[WIDTH], w_sum[WIDTH:1]};
  assign o_q  = {w_sum[0], i_q[WIDTH-1:1]};
  assign o_q1 = i_q[0];

endmodule

// File: rtl/mult_booth.sv
// Sequential signed radix-2 Booth multiplier, one step per clock.
// A one-cycle multControl pulse loads the operands; WIDTH edges later
// hi/lo carry the full 2*WIDTH-bit product and multStop pulses for one
// cycle. A multControl pulse at any time (re)starts an operation.
// Ports:
//   clk, reset        clock, synchronous active-high reset
//   a, b              signed operands, sampled on the start edge only
//   multControl       start request
//   multBusy          high while iterating
//   multStop          one-cycle done pulse
//   hi, lo            upper / lower product halves, held until next result
module mult_booth
  import cpu_pkg::*;
#(
  parameter int WIDTH = MULT_WIDTH
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             multControl,
  output logic             multBusy,
  output logic             multStop,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int CNT_W = $clog2(WIDTH) + 1;

  mult_state_t      r_state, w_next;
  logic [WIDTH:0]   r_m, r_a, w_a;
  logic [WIDTH-1:0] r_q, w_q;
  logic             r_q1, w_q1;
  logic [CNT_W-1:0] r_cnt;
  logic [WIDTH-1:0] r_hi, r_lo;
  logic             w_last;

  mult_booth_step #(.WIDTH(WIDTH)) u_step (
    .i_a  (r_a),
    .i_m  (r_m),
    .i_q  (r_q),
    .i_q1 (r_q1),
    .o_a  (w_a),
    .o_q  (w_q),
    .o_q1 (w_q1)
  );

  assign w_last = (r_state == RUN) && (r_cnt == CNT_W'(1));

  // State register
  always_ff @(posedge clk) begin
    if (reset) r_state <= IDLE;
    else       r_state <= w_next;
  end

  // Next state: a start request wins in every state (abort/restart in RUN)
  always_comb begin
    w_next = r_state;
    if (multControl) begin
      w_next = RUN;
    end else begin
      case (r_state)
        IDLE:    w_next = IDLE;
        RUN:     w_next = w_last ? DONE : RUN;
        DONE:    w_next = IDLE;
        default: w_next = IDLE;
      endcase
    end
  end

  // Outputs decoded from state
  always_comb begin
    multBusy = 1'b0;
    multStop = 1'b0;
    case (r_state)
      RUN:     multBusy = 1'b1;
      DONE:    multStop = 1'b1;
      default: ;
    endcase
  end

  // Datapath, counter and result registers
  always_ff @(posedge clk) begin
    if (reset) begin
      r_m   <= '0;
      r_a   <= '0;
      r_q   <= '0;
      r_q1  <= 1'b0;
      r_cnt <= '0;
      r_hi  <= '0;
      r_lo  <= '0;
    end else if (multControl) begin
      r_m   <= {a[WIDTH-1], a};
      r_a   <= '0;
      r_q   <= b;
      r_q1  <= 1'b0;
      r_cnt <= CNT_W'(WIDTH);
    end else if (r_state == RUN) begin
      r_a   <= w_a;
      r_q   <= w_q;
      r_q1  <= w_q1;
      r_cnt <= r_cnt - CNT_W'(1);
      // Final step: capture the post-shift product; A's extra bit is only
      // a sign copy by now and is dropped.
      if (w_last) begin
        r_hi <= w_a[WIDTH-1:0];
        r_lo <= w_q;
      end
    end
  end

  assign hi = r_hi;
  assign lo = r_lo;

endmodule

// File: tb/tb_mult_booth.sv
module tb_mult_booth;

  localparam int W = 32;

  logic         clk = 1'b0;
  logic         reset;
  logic [W-1:0] a, b;
  logic         multControl;
  logic         multBusy, multStop;
  logic [W-1:0] hi, lo;

  always #5 clk = ~clk;

  mult_booth #(.WIDTH(W)) dut (
    .clk         (clk),
    .reset       (reset),
    .a           (a),
    .b           (b),
    .multControl (multControl),
    .multBusy    (multBusy),
    .multStop    (multStop),
    .hi          (hi),
    .lo          (lo)
  );

  typedef struct {
    logic [63:0] prod;
    int          cyc;
  } exp_t;

  exp_t sb[$];
  int   cyc = 0;
  int   checks = 0;
  int   passes = 0;
  logic prev_stop = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [63:0] ref_mul(input logic [W-1:0] x, input logic [W-1:0] y);
    longint p;
    p = longint'($signed(x)) * longint'($signed(y));
    return p;
  endfunction

  task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got === exp) passes++;
    else $display("FAIL %s: got %h expected %h (t=%0t)", nm, got, exp, $time);
  endtask

  // Monitor: every multStop must match the oldest pending operation,
  // both in value and in the cycle it appears.
  always @(negedge clk) begin
    if (reset) begin
      prev_stop = 1'b0;
    end else begin
      if (multStop) begin
        chk("stop_width", {63'd0, prev_stop}, 64'd0);
        if (sb.size() == 0) begin
          chk("unexpected_stop", 64'd1, 64'd0);
        end else begin
          exp_t e;
          e = sb.pop_front();
          chk("product", {hi, lo}, e.prod);
          chk("latency", 64'(cyc), 64'(e.cyc));
        end
      end
      prev_stop = multStop;
    end
  end

  // Called at a negedge: present operands and a one-cycle start pulse.
  task automatic issue(input logic [W-1:0] x, input logic [W-1:0] y);
    exp_t e;
    a = x;
    b = y;
    multControl = 1'b1;
    e.prod = ref_mul(x, y);
    e.cyc  = cyc + 1 + W;
    sb.push_back(e);
    @(posedge clk);
    #1;
    multControl = 1'b0;
    a = $urandom;
    b = $urandom;
  endtask

  task automatic go(input logic [W-1:0] x, input logic [W-1:0] y);
    @(negedge clk);
    issue(x, y);
  endtask

  task automatic wait_done(output int busy_cycles);
    busy_cycles = 0;
    for (int i = 0; i < 200 && sb.size() != 0; i++) begin
      @(negedge clk);
      if (multBusy) busy_cycles++;
      #1;
    end
    chk("done_timeout", 64'(sb.size()), 64'd0);
  endtask

  logic [W-1:0] specials [6] = '{32'h0, 32'h1, 32'hFFFFFFFF, 32'h80000000, 32'h7FFFFFFF, 32'h2};

  initial begin
    int bc;
    logic [63:0] held;
    logic [W-1:0] x, y;

    reset = 1'b1;
    multControl = 1'b0;
    a = '0;
    b = '0;
    repeat (3) @(negedge clk);
    chk("reset_hi", 64'(hi), 64'd0);
    chk("reset_lo", 64'(lo), 64'd0);
    chk("reset_busy", 64'(multBusy), 64'd0);
    chk("reset_stop", 64'(multStop), 64'd0);

    // Reset wins over a start in the same cycle
    multControl = 1'b1;
    a = 32'd5;
    b = 32'd5;
    @(negedge clk);
    multControl = 1'b0;
    chk("reset_priority_busy", 64'(multBusy), 64'd0);
    reset = 1'b0;

    // Directed cases
    go(32'd7, 32'd3);
    wait_done(bc);
    chk("busy_cycles", 64'(bc), 64'(W));
    go(32'hFFFFFFFB, 32'd4);                  wait_done(bc);
    go(32'h80000000, 32'h80000000);           wait_done(bc);
    go(32'hFFFFFFFF, 32'hFFFFFFFF);           wait_done(bc);
    go(32'd0, 32'd0);                         wait_done(bc);
    chk("zero_busy_cycles", 64'(bc), 64'(W));

    // Reset mid-run: operation dropped, outputs cleared
    go(32'd2, 32'd3);
    repeat (9) @(negedge clk);
    void'(sb.pop_back());
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk("midreset_hilo", {hi, lo}, 64'd0);
    chk("midreset_busy", 64'(multBusy), 64'd0);
    repeat (40) @(negedge clk);
    go(32'd6, 32'd7);                         wait_done(bc);

    // Abort and restart mid-run: only the second result appears
    go(32'd2, 32'd3);
    repeat (4) @(negedge clk);
    void'(sb.pop_back());
    go(32'd6, 32'd7);
    wait_done(bc);
    repeat (40) @(negedge clk);

    // Back-to-back: restart in the DONE cycle
    go(32'd9, 32'd9);
    held = ref_mul(32'd9, 32'd9);
    for (int i = 0; i < 100 && !multStop; i++) @(negedge clk);
    chk("b2b_stop_seen", 64'(multStop), 64'd1);
    issue(32'hFFFFFFFF, 32'd1);
    repeat (5) @(negedge clk);
    chk("b2b_hold", {hi, lo}, held);
    chk("b2b_busy", 64'(multBusy), 64'd1);
    wait_done(bc);

    // Randomized operations with random idle gaps
    for (int n = 0; n < 24; n++) begin
      x = ($urandom_range(0, 3) == 0) ? specials[$urandom_range(0, 5)] : $urandom;
      y = ($urandom_range(0, 3) == 0) ? specials[$urandom_range(0, 5)] : $urandom;
      repeat ($urandom_range(0, 3)) @(negedge clk);
      go(x, y);
      wait_done(bc);
    end

    // Idle tail: catches any stray multStop
    repeat (40) @(negedge clk);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, %0d/%0d passed", passes, checks);
    $fatal(1);
  end

endmodule

// File: doc/mult_booth.md
Name: mult_booth

Overview:
- Sequential signed multiplier for the CPU datapath; the multiply counterpart of the iterative divider feeding the same hi/lo registers.
- Radix-2 Booth algorithm, one step per clock. Same start-pulse / stop-pulse handshake as the divider, so the control unit drives both identically.
- Produces the full 2*WIDTH-bit signed product: upper half on hi, lower half on lo.

Parameters:
- WIDTH, 32, operand width; product is 2*WIDTH bits split across hi/lo.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- a  in  WIDTH  multiplicand (signed, two's complement)
- b  in  WIDTH  multiplier (signed, two's complement)
- multControl  in  1  start request, sampled on rising clk edge
- multBusy  out  1  high while iterating (RUN state)
- multStop  out  1  one-cycle done pulse; hi/lo valid when high
- hi  out  WIDTH  product[2*WIDTH-1:WIDTH]
- lo  out  WIDTH  product[WIDTH-1:0]

Behaviour:
- Clock and reset: clk; reset synchronous, active-high. Reset has priority over everything, including multControl in the same cycle.
- Reset values: hi=0, lo=0, multStop=0, multBusy=0, state=IDLE, count=0, internal regs=0.
- Internal registers:
  - M: WIDTH+1, a sign-extended.
  - A: WIDTH+1 accumulator; the extra bit absorbs the -2^(WIDTH-1) overflow.
  - Q: WIDTH.
  - q_1: 1 bit.
  - count: clog2(WIDTH)+1 bits.
- States: IDLE, RUN, DONE.
- IDLE:
  - multControl=1 at edge k loads M=sext(a), A=0, Q=b, q_1=0, count=WIDTH.
  - Next state RUN; multBusy=1 from edge k.
- RUN, each edge performs one Booth step:
  - {Q[0],q_1}=01: A=A+M.
  - {Q[0],q_1}=10: A=A-M.
  - 00 or 11: no add.
  - Then arithmetic shift right of {A,Q,q_1} by 1 (A MSB replicated); count decrements.
- Last step (count==1 at the edge):
  - In the same edge, write hi={A,Q} bits [2*WIDTH-1:WIDTH] and lo=Q, taken from the post-shift values.
  - Set multStop=1, multBusy=0; next state DONE.
- Latency: start sampled at edge k; multStop high in the cycle following edge k+WIDTH. For WIDTH=32, that is 32 edges after the start edge.
- DONE: lasts one cycle; multStop returns to 0 at the next edge and the state returns to IDLE.
- hi/lo hold the last result until the next completion. They are not cleared on start.
- multControl during RUN: abort and restart. Reload from current a/b, count=WIDTH, no multStop for the aborted operation.
- multControl during DONE: multStop still deasserts at that edge; operation loads as from IDLE.
- multControl held high in IDLE for several cycles: each high edge reloads, so the operation effectively starts at the last high edge. The control unit must pulse it for one cycle.
- Reset mid-RUN: operation discarded, no multStop, hi/lo=0.
- Boundary cases:
  - Operands of 0 complete in full WIDTH cycles; there is no early termination.
  - -2^(WIDTH-1) * -2^(WIDTH-1) must produce +2^(2*WIDTH-2) exactly.
- a/b need only be stable at the start edge; they are ignored afterwards.

Decomposition:
- Shared CPU package (cpu_pkg):
  - MULT_WIDTH=32.
  - mult_state_t enum {IDLE,RUN,DONE}.
  - Booth code constants BOOTH_ADD=2'b01 and BOOTH_SUB=2'b10.
- One natural sub-module: mult_booth_step.
  - Combinational.
  - Inputs: A, Q, q_1, M.
  - Outputs: next A, Q, q_1 after add/sub and arithmetic shift.
  - The top holds the FSM, counter and output registers.

Test Plan:
- a=7, b=3, 1-cycle multControl -> multBusy high 32 cycles; multStop single pulse 32 edges after start; hi=0x00000000, lo=0x00000015.
- a=-5 (0xFFFFFFFB), b=4 -> hi=0xFFFFFFFF, lo=0xFFFFFFEC.
- a=0x80000000, b=0x80000000 -> hi=0x40000000, lo=0x00000000; a=0xFFFFFFFF, b=0xFFFFFFFF -> hi=0, lo=1.
- Start 2*3, assert reset at step 10 -> multStop never pulses, hi=lo=0, multBusy=0; a fresh start afterwards (6*7) gives lo=42.
- Start 2*3, at step 5 pulse multControl with a=6, b=7 -> exactly one multStop, 32 edges after the second start; lo=42, hi=0.
- Back-to-back: multControl in the DONE cycle of 9*9 -> multStop for 81 lasts one cycle; second result (-1*1: hi=lo=0xFFFFFFFF) arrives 32 edges later; hi/lo hold 81 meanwhile.
